rstatus_exception_queue: RTL and testbench

Successor to the combinational overflow-code decoder. Decodes ALU overflow events (add/addi/sub) and multi-cycle multdiv exceptions (mul/div), and queues the resulting $rstatus codes in a parametrised FIFO. The queue drains them to the regfile write port through a valid/ready handshake. It also holds the last committed status code and a sticky overrun flag. It sits between the X/MD stages and the writeback arbiter.

---
 rtl/rstatus_exception_queue.sv | 257 +++++++++++++++++++++++++
 tb/tb_rstatus_exception_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rstatus_exception_queue.sv
// ---------------------------------------------------------------------------
// rstatus_exception_queue
//
// Decodes ALU overflow events (add / addi / sub) and multdiv exceptions
// (mul / div) into $rstatus codes. The codes are queued in a small FIFO and
// drained to the regfile write port through a valid/ready handshake. The
// block also keeps the last code accepted by writeback and a sticky overrun
// flag that records any event lost because the queue had no room.
//
// Ports:
//   clock          system clock, all state changes on the rising edge
//   reset_n        synchronous active-low reset
//   alu_valid      X-stage instruction valid
//   alu_opcode     X-stage opcode
//   alu_aluop      X-stage ALU op field
//   alu_ovf        ALU overflow flag for the X-stage instruction
//   md_done        multdiv result ready (single-cycle pulse)
//   md_is_div      completing multdiv op is a div (1) or a mul (0)
//   md_exception   multdiv overflow / divide-by-zero
//   wb_ready       writeback accepts a status write this cycle
//   clear_status   clears status_q and overrun
//   st_valid       head entry valid for writeback
//   st_addr        regfile index for status writes (constant)
//   st_data        head status code, 0 when the queue is empty
//   status_q       last code accepted by writeback
//   pending_count  number of occupied queue entries
//   overrun        sticky flag, set when an event is dropped
// ---------------------------------------------------------------------------
module rstatus_exception_queue #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned RSTATUS_REG = 30,
    parameter int unsigned CODE_ADD    = 1,
    parameter int unsigned CODE_ADDI   = 2,
    parameter int unsigned CODE_SUB    = 3,
    parameter int unsigned CODE_MUL    = 4,
    parameter int unsigned CODE_DIV    = 5
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                alu_valid,
    input  logic [4:0]                          alu_opcode,
    input  logic [4:0]                          alu_aluop,
    input  logic                                alu_ovf,
    input  logic                                md_done,
    input  logic                                md_is_div,
    input  logic                                md_exception,
    input  logic                                wb_ready,
    input  logic                                clear_status,
    output logic                                st_valid,
    output logic [4:0]                          st_addr,
    output logic [DATA_WIDTH-1:0]               st_data,
    output logic [DATA_WIDTH-1:0]               status_q,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     pending_count,
    output logic                                overrun
);

    // Count needs one more state than the depth; free-space math gets a
    // further guard bit so that depth - count + pop can never wrap.
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned FW = CW + 1;

    localparam logic [4:0] OP_RTYPE   = 5'b00000;
    localparam logic [4:0] OP_ADDI    = 5'b00101;
    localparam logic [4:0] ALUOP_ADD  = 5'b00000;
    localparam logic [4:0] ALUOP_SUB  = 5'b00001;

    // Storage and state
    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr_r;
    logic [PW-1:0]         wr_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  st_valid_r;
    logic [DATA_WIDTH-1:0] st_data_r;
    logic [DATA_WIDTH-1:0] status_q_r;
    logic                  overrun_r;

    // Combinational intermediates
    logic                  alu_hit_s;
    logic [DATA_WIDTH-1:0] alu_code_s;
    logic                  md_hit_s;
    logic [DATA_WIDTH-1:0] md_code_s;
    logic [DATA_WIDTH-1:0] first_code_s;
    logic [DATA_WIDTH-1:0] second_code_s;
    logic [1:0]            n_req_s;
    logic [1:0]            n_acc_s;
    logic                  drop_s;
    logic                  pop_s;
    logic [FW-1:0]         free_s;
    logic [CW-1:0]         remain_s;
    logic [CW-1:0]         count_next_s;
    logic [PW-1:0]         rd_next_s;
    logic [PW-1:0]         wr_next_s;
    logic [PW-1:0]         wr_plus1_s;
    logic [DATA_WIDTH-1:0] head_next_s;

    // Decodes the X-stage instruction into an ALU overflow code
    always_comb begin
        alu_hit_s  = 1'b0;
        alu_code_s = {DATA_WIDTH{1'b0}};
        if (alu_valid && alu_ovf) begin
            case (alu_opcode)
                OP_RTYPE: begin
                    // ALU-path mul/div and every other aluop are ignored;
                    // multdiv faults arrive only through the MD interface.
                    case (alu_aluop)
                        ALUOP_ADD: begin
                            alu_hit_s  = 1'b1;
                            alu_code_s = DATA_WIDTH'(CODE_ADD);
                        end
                        ALUOP_SUB: begin
                            alu_hit_s  = 1'b1;
                            alu_code_s = DATA_WIDTH'(CODE_SUB);
                        end
                        default: begin
                            alu_hit_s  = 1'b0;
                            alu_code_s = {DATA_WIDTH{1'b0}};
                        end
                    endcase
                end
                OP_ADDI: begin
                    alu_hit_s  = 1'b1;
                    alu_code_s = DATA_WIDTH'(CODE_ADDI);
                end
                default: begin
                    alu_hit_s  = 1'b0;
                    alu_code_s = {DATA_WIDTH{1'b0}};
                end
            endcase
        end else begin
            alu_hit_s  = 1'b0;
            alu_code_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Decodes the multdiv completion into a mul/div exception code
    always_comb begin
        md_hit_s = md_done & md_exception;
        if (md_is_div) begin
            md_code_s = DATA_WIDTH'(CODE_DIV);
        end else begin
            md_code_s = DATA_WIDTH'(CODE_MUL);
        end
    end

    // Orders pushes, checks for room and computes next queue state
    always_comb begin
        // The multdiv op is the older instruction, so its code goes first.
        if (md_hit_s) begin
            first_code_s = md_code_s;
        end else begin
            first_code_s = alu_code_s;
        end
        second_code_s = alu_code_s;

        n_req_s = {1'b0, md_hit_s} + {1'b0, alu_hit_s};
        pop_s   = st_valid_r & wb_ready;

        // A pop on the same edge frees a slot for the incoming events.
        free_s = FW'(FIFO_DEPTH) - FW'(count_r) + FW'(pop_s);

        // When room is short, the oldest request (first_code_s) is the one
        // kept, so a single free slot keeps the MD code and drops the ALU one.
        if (free_s >= FW'(n_req_s)) begin
            n_acc_s = n_req_s;
            drop_s  = 1'b0;
        end else begin
            n_acc_s = free_s[1:0];
            drop_s  = 1'b1;
        end

        count_next_s = count_r - CW'(pop_s) + CW'(n_acc_s);
        remain_s     = count_r - CW'(pop_s);
        rd_next_s    = rd_ptr_r + PW'(pop_s);
        wr_next_s    = wr_ptr_r + PW'(n_acc_s);
        wr_plus1_s   = wr_ptr_r + PW'(1);

        // Next head: an entry already stored if any survive the pop,
        // otherwise the first code pushed this cycle, otherwise zero.
        // Surviving entries are never overwritten, so reading mem_r here
        // is safe even while new codes are being written.
        if (remain_s != {CW{1'b0}}) begin
            head_next_s = mem_r[rd_next_s];
        end else if (n_acc_s != 2'd0) begin
            head_next_s = first_code_s;
        end else begin
            head_next_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Queue storage: writes accepted codes into free slots
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (n_acc_s != 2'd0) begin
                mem_r[wr_ptr_r] <= first_code_s;
            end
            if (n_acc_s == 2'd2) begin
                mem_r[wr_plus1_s] <= second_code_s;
            end
        end
    end

    // Pointers, occupancy and the registered head view
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            st_valid_r <= 1'b0;
            st_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_ptr_r   <= rd_next_s;
            wr_ptr_r   <= wr_next_s;
            count_r    <= count_next_s;
            st_valid_r <= (count_next_s != {CW{1'b0}});
            st_data_r  <= head_next_s;
        end
    end

    // Last committed code and sticky overrun flag
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            status_q_r <= {DATA_WIDTH{1'b0}};
            overrun_r  <= 1'b0;
        end else begin
            // A pop on the clear edge still records the accepted code.
            if (pop_s) begin
                status_q_r <= st_data_r;
            end else if (clear_status) begin
                status_q_r <= {DATA_WIDTH{1'b0}};
            end else begin
                status_q_r <= status_q_r;
            end
            // A drop on the clear edge keeps the flag set.
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (clear_status) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign st_valid      = st_valid_r;
    assign st_addr       = 5'(RSTATUS_REG);
    assign st_data       = st_data_r;
    assign status_q      = status_q_r;
    assign pending_count = count_r;
    assign overrun       = overrun_r;

endmodule

// File: tb/tb_rstatus_exception_queue.sv
module tb_rstatus_exception_queue;

    logic        clock;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_opcode;
    logic [4:0]  alu_aluop;
    logic        alu_ovf;
    logic        md_done;
    logic        md_is_div;
    logic        md_exception;
    logic        wb_ready;
    logic        clear_status;
    logic        st_valid;
    logic [4:0]  st_addr;
    logic [31:0] st_data;
    logic [31:0] status_q;
    logic [2:0]  pending_count;
    logic        overrun;

    int checks;
    int errors;

    rstatus_exception_queue dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .alu_valid     (alu_valid),
        .alu_opcode    (alu_opcode),
        .alu_aluop     (alu_aluop),
        .alu_ovf       (alu_ovf),
        .md_done       (md_done),
        .md_is_div     (md_is_div),
        .md_exception  (md_exception),
        .wb_ready      (wb_ready),
        .clear_status  (clear_status),
        .st_valid      (st_valid),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .status_q      (status_q),
        .pending_count (pending_count),
        .overrun       (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid    = 1'b0;
        alu_opcode   = 5'd0;
        alu_aluop    = 5'd0;
        alu_ovf      = 1'b0;
        md_done      = 1'b0;
        md_is_div    = 1'b0;
        md_exception = 1'b0;
        clear_status = 1'b0;
    endtask

    task automatic alu_event(input logic [4:0] op, input logic [4:0] aop);
        alu_valid  = 1'b1;
        alu_opcode = op;
        alu_aluop  = aop;
        alu_ovf    = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        wb_ready = 1'b0;
        reset_n  = 1'b0;
        tick();
        reset_n  = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (st_valid !== 1'b0) begin errors++; $display("FAIL reset_st_valid got %0d exp 0", st_valid); end
        checks++; if (st_data !== 32'd0) begin errors++; $display("FAIL reset_st_data got %0d exp 0", st_data); end
        checks++; if (status_q !== 32'd0) begin errors++; $display("FAIL reset_status_q got %0d exp 0", status_q); end
        checks++; if (pending_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", pending_count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0d exp 0", overrun); end
        checks++; if (st_addr !== 5'd30) begin errors++; $display("FAIL st_addr got %0d exp 30", st_addr); end
    endtask

    task automatic test_single_add();
        wb_ready = 1'b1;
        alu_event(5'b00000, 5'b00000);
        tick();
        idle_inputs();
        checks++; if (st_valid !== 1'b1) begin errors++; $display("FAIL add_st_valid got %0d exp 1", st_valid); end
        checks++; if (st_data !== 32'd1) begin errors++; $display("FAIL add_st_data got %0d exp 1", st_data); end
        checks++; if (pending_count !== 3'd1) begin errors++; $display("FAIL add_count got %0d exp 1", pending_count); end
        tick();
        checks++; if (status_q !== 32'd1) begin errors++; $display("FAIL add_status_q got %0d exp 1", status_q); end
        checks++; if (pending_count !== 3'd0) begin errors++; $display("FAIL add_count_drained got %0d exp 0", pending_count); end
        checks++; if (st_valid !== 1'b0) begin errors++; $display("FAIL add_st_valid_drained got %0d exp 0", st_valid); end
        checks++; if (st_data !== 32'd0) begin errors++; $display("FAIL add_st_data_empty got %0d exp 0", st_data); end
        wb_ready = 1'b0;
    endtask

    task automatic test_md_alu_order();
        wb_ready = 1'b0;
        alu_event(5'b00101, 5'b00000);
        md_done = 1'b1; md_is_div = 1'b1; md_exception = 1'b1;
        tick();
        idle_inputs();
        checks++; if (pending_count !== 3'd2) begin errors++; $display("FAIL order_count got %0d exp 2", pending_count); end
        checks++; if (st_data !== 32'd5) begin errors++; $display("FAIL order_head got %0d exp 5", st_data); end
        wb_ready = 1'b1;
        tick();
        checks++; if (status_q !== 32'd5) begin errors++; $display("FAIL order_first got %0d exp 5", status_q); end
        checks++; if (st_data !== 32'd2) begin errors++; $display("FAIL order_second_head got %0d exp 2", st_data); end
        tick();
        checks++; if (status_q !== 32'd2) begin errors++; $display("FAIL order_second got %0d exp 2", status_q); end
        checks++; if (pending_count !== 3'd0) begin errors++; $display("FAIL order_empty got %0d exp 0", pending_count); end
        wb_ready = 1'b0;
    endtask

    task automatic test_overrun();
        wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            alu_event(5'b00000, 5'b00001);
            tick();
        end
        idle_inputs();
        checks++; if (pending_count !== 3'd4) begin errors++; $display("FAIL ovr_count got %0d exp 4", pending_count); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %0d exp 1", overrun); end
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (status_q !== 32'd3) begin errors++; $display("FAIL ovr_drain%0d got %0d exp 3", i, status_q); end
        end
        checks++; if (st_valid !== 1'b0) begin errors++; $display("FAIL ovr_st_valid_end got %0d exp 0", st_valid); end
        wb_ready = 1'b0;
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear_flag got %0d exp 0", overrun); end
        checks++; if (status_q !== 32'd0) begin errors++; $display("FAIL ovr_clear_status got %0d exp 0", status_q); end
    endtask

    task automatic test_full_pop_push();
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            alu_event(5'b00000, 5'b00001);
            tick();
        end
        // Full queue: a pop and an addi on the same edge must not drop.
        wb_ready = 1'b1;
        alu_event(5'b00101, 5'b00000);
        tick();
        idle_inputs();
        checks++; if (pending_count !== 3'd4) begin errors++; $display("FAIL fpp_count got %0d exp 4", pending_count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fpp_overrun got %0d exp 0", overrun); end
        checks++; if (status_q !== 32'd3) begin errors++; $display("FAIL fpp_status_q got %0d exp 3", status_q); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (status_q !== ((i == 3) ? 32'd2 : 32'd3)) begin
                errors++; $display("FAIL fpp_drain%0d got %0d exp %0d", i, status_q, (i == 3) ? 2 : 3);
            end
        end
        checks++; if (pending_count !== 3'd0) begin errors++; $display("FAIL fpp_empty got %0d exp 0", pending_count); end
        wb_ready = 1'b0;
    endtask

    task automatic test_two_events_one_slot();
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alu_event(5'b00000, 5'b00001);
            tick();
        end
        alu_event(5'b00000, 5'b00000);
        md_done = 1'b1; md_is_div = 1'b0; md_exception = 1'b1;
        tick();
        idle_inputs();
        checks++; if (pending_count !== 3'd4) begin errors++; $display("FAIL one_slot_count got %0d exp 4", pending_count); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL one_slot_overrun got %0d exp 1", overrun); end
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (status_q !== ((i == 3) ? 32'd4 : 32'd3)) begin
                errors++; $display("FAIL one_slot_drain%0d got %0d exp %0d", i, status_q, (i == 3) ? 4 : 3);
            end
        end
        wb_ready = 1'b0;
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
    endtask

    task automatic test_mul_path();
        wb_ready = 1'b0;
        alu_event(5'b00000, 5'b00110);
        tick();
        idle_inputs();
        checks++; if (pending_count !== 3'd0) begin errors++; $display("FAIL alu_mul_count got %0d exp 0", pending_count); end
        alu_event(5'b01111, 5'b00000);
        md_done = 1'b1; md_is_div = 1'b0; md_exception = 1'b0;
        tick();
        idle_inputs();
        checks++; if (st_valid !== 1'b0) begin errors++; $display("FAIL no_exc_st_valid got %0d exp 0", st_valid); end
        md_done = 1'b1; md_is_div = 1'b0; md_exception = 1'b1;
        tick();
        idle_inputs();
        checks++; if (pending_count !== 3'd1) begin errors++; $display("FAIL md_mul_count got %0d exp 1", pending_count); end
        checks++; if (st_data !== 32'd4) begin errors++; $display("FAIL md_mul_code got %0d exp 4", st_data); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        checks++; if (status_q !== 32'd4) begin errors++; $display("FAIL md_mul_status got %0d exp 4", status_q); end
    endtask

    task automatic test_reset_mid();
        wb_ready = 1'b0;
        alu_event(5'b00000, 5'b00001);
        tick();
        alu_event(5'b00000, 5'b00000);
        tick();
        idle_inputs();
        checks++; if (pending_count !== 3'd2) begin errors++; $display("FAIL mid_pre_count got %0d exp 2", pending_count); end
        wb_ready = 1'b1;
        reset_n  = 1'b0;
        tick();
        reset_n  = 1'b1;
        wb_ready = 1'b0;
        checks++; if (pending_count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", pending_count); end
        checks++; if (st_valid !== 1'b0) begin errors++; $display("FAIL mid_st_valid got %0d exp 0", st_valid); end
        checks++; if (status_q !== 32'd0) begin errors++; $display("FAIL mid_status_q got %0d exp 0", status_q); end
        tick();
        checks++; if (st_valid !== 1'b0) begin errors++; $display("FAIL mid_after_st_valid got %0d exp 0", st_valid); end
    endtask

    task automatic test_clear_drop();
        wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            alu_event(5'b00000, 5'b00001);
            tick();
        end
        idle_inputs();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL cd_set got %0d exp 1", overrun); end
        clear_status = 1'b1;
        alu_event(5'b00000, 5'b00001);
        tick();
        idle_inputs();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL cd_drop_wins got %0d exp 1", overrun); end
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL cd_clear got %0d exp 0", overrun); end
        checks++; if (pending_count !== 3'd4) begin errors++; $display("FAIL cd_fifo_kept got %0d exp 4", pending_count); end
        clear_status = 1'b1;
        wb_ready = 1'b1;
        tick();
        clear_status = 1'b0;
        wb_ready = 1'b0;
        checks++; if (status_q !== 32'd3) begin errors++; $display("FAIL cd_pop_wins got %0d exp 3", status_q); end
        checks++; if (pending_count !== 3'd3) begin errors++; $display("FAIL cd_pop_count got %0d exp 3", pending_count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        wb_ready = 1'b0;
        reset_n  = 1'b0;
        test_reset();
        test_single_add();
        test_md_alu_order();
        test_overrun();
        test_full_pop_push();
        test_two_events_one_slot();
        test_mul_path();
        test_reset_mid();
        test_clear_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
